gap_frame_scheduler: RTL and testbench

Sequencing controller placed in front of the global average pooling unit. Accepts a pixel stream with a valid/ready handshake and admits exactly IMG_WIDTH*IMG_HEIGHT pixel words per frame into the pooling datapath. It then blocks further input until the pooling unit returns its per-channel averages. The result is held in an output register with a valid/ready handshake, and the block watches for a pooling result that never arrives.

---
 rtl/gap_frame_scheduler.sv | 170 +++++++++++++++++
 tb/tb_gap_frame_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gap_frame_scheduler.sv
// gap_frame_scheduler
// Sits in front of the global average pooling unit. Admits exactly
// IMG_WIDTH*IMG_HEIGHT pixel words per frame, then blocks input until the
// pooling unit returns its per-channel averages. The result is held in an
// output register behind a valid/ready handshake. If no result arrives
// within TIMEOUT cycles, the frame is aborted.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start              begin a frame (only honoured in IDLE)
//   s_data/s_valid/s_ready          upstream pixel stream
//   pool_clear         one-cycle clear pulse to the pooling unit
//   pool_data/pool_valid            registered feed to the pooling unit
//   pool_result/pool_result_valid   averages returned by the pooling unit
//   m_data/m_valid/m_ready          held frame result to downstream
//   busy               controller not idle
//   frame_done         one-cycle pulse on result handoff
//   timeout_err        sticky abort flag, cleared by the next start
//   pixel_cnt          pixels admitted in the current frame
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | waiting for start
// STREAM   | admitting pixel words until N have been taken
// WAIT_RES | input blocked, waiting for the pooling result
// HOLD     | result held on m_data until downstream takes it

module gap_frame_scheduler #(
  parameter int DATA_WIDHT = 32,
  parameter int CHANNEL    = 7,
  parameter int IMG_WIDTH  = 44,
  parameter int IMG_HEIGHT = 44,
  parameter int TIMEOUT    = 64,
  localparam int N  = IMG_WIDTH * IMG_HEIGHT,
  localparam int DW = DATA_WIDHT * CHANNEL,
  localparam int CW = $clog2(N + 1),
  localparam int WW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          pool_clear,
  output logic [DW-1:0] pool_data,
  output logic          pool_valid,
  input  logic [DW-1:0] pool_result,
  input  logic          pool_result_valid,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          timeout_err,
  output logic [CW-1:0] pixel_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          w_start;
  logic          w_xfer;
  logic          w_last;
  logic          w_capture;
  logic          w_timeout;
  logic          w_handoff;
  logic [WW-1:0] r_wait;
  logic [CW-1:0] r_pixel_cnt;
  logic [DW-1:0] r_pool_data;
  logic [DW-1:0] r_m_data;
  logic          r_pool_valid;
  logic          r_pool_clear;
  logic          r_m_valid;
  logic          r_frame_done;
  logic          r_timeout_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_xfer       = 1'b0;
    w_last       = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_handoff    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start = start;
        if (start) w_next_state = ST_STREAM;
      end
      ST_STREAM: begin
        w_xfer = s_valid;
        w_last = s_valid && (r_pixel_cnt == CW'(N - 1));
        if (w_last) w_next_state = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        // A result arriving on the timeout edge still wins.
        w_capture = pool_result_valid;
        w_timeout = !pool_result_valid && (r_wait == WW'(TIMEOUT - 1));
        if (w_capture)      w_next_state = ST_HOLD;
        else if (w_timeout) w_next_state = ST_IDLE;
      end
      ST_HOLD: begin
        w_handoff = m_ready;
        if (m_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait        <= '0;
      r_pixel_cnt   <= '0;
      r_pool_data   <= '0;
      r_pool_valid  <= 1'b0;
      r_pool_clear  <= 1'b0;
      r_m_data      <= '0;
      r_m_valid     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_pool_clear <= w_start;
      r_frame_done <= w_handoff;
      r_pool_valid <= w_xfer;
      if (w_xfer) r_pool_data <= s_data;

      if (w_start)     r_pixel_cnt <= '0;
      else if (w_xfer) r_pixel_cnt <= r_pixel_cnt + 1'b1;

      // Counter is zero on the first WAIT_RES cycle because it is held
      // at zero in every other state.
      if (r_state == ST_WAIT_RES) r_wait <= r_wait + 1'b1;
      else                        r_wait <= '0;

      if (w_start)        r_timeout_err <= 1'b0;
      else if (w_timeout) r_timeout_err <= 1'b1;

      if (w_capture) begin
        r_m_data  <= pool_result;
        r_m_valid <= 1'b1;
      end else if (w_handoff) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign s_ready     = (r_state == ST_STREAM);
  assign busy        = (r_state != ST_IDLE);
  assign pool_clear  = r_pool_clear;
  assign pool_data   = r_pool_data;
  assign pool_valid  = r_pool_valid;
  assign m_data      = r_m_data;
  assign m_valid     = r_m_valid;
  assign frame_done  = r_frame_done;
  assign timeout_err = r_timeout_err;
  assign pixel_cnt   = r_pixel_cnt;

endmodule

// File: tb/tb_gap_frame_scheduler.sv
module tb_gap_frame_scheduler;
  localparam int DWID = 32;
  localparam int CH   = 7;
  localparam int IW   = 2;
  localparam int IH   = 2;
  localparam int TO   = 8;
  localparam int N    = IW * IH;
  localparam int DW   = DWID * CH;
  localparam int CW   = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          pool_clear;
  logic [DW-1:0] pool_data;
  logic          pool_valid;
  logic [DW-1:0] pool_result;
  logic          pool_result_valid;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          frame_done;
  logic          timeout_err;
  logic [CW-1:0] pixel_cnt;

  int total = 0;
  int bad   = 0;

  gap_frame_scheduler #(
    .DATA_WIDHT(DWID), .CHANNEL(CH), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pool_clear(pool_clear), .pool_data(pool_data), .pool_valid(pool_valid),
    .pool_result(pool_result), .pool_result_valid(pool_result_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
    .pixel_cnt(pixel_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < CH; i++) w[i*DWID +: DWID] = $urandom;
    return w;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pool_clear"}, pool_clear, 0);
    chk({tag, "_pool_valid"}, pool_valid, 0);
    chk({tag, "_pool_data"}, pool_data, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_pixel_cnt"}, pixel_cnt, 0);
  endtask

  // One frame from start to handoff (or timeout).
  // mode: 0 = s_valid always high, 1 = toggle 1,0,..., 2 = random.
  // lat < 0 means the pooling model never answers.
  task automatic do_frame(input logic [DW-1:0] res, input int lat, input int hold,
                          input int mode);
    int            cnt;
    int            it;
    logic          v;
    logic [DW-1:0] w;
    logic [DW-1:0] last_w;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_pool_clear", pool_clear, 1);
    chk("start_busy", busy, 1);
    chk("start_s_ready", s_ready, 1);
    chk("start_pixel_cnt", pixel_cnt, 0);
    chk("start_timeout_clr", timeout_err, 0);

    cnt = 0;
    it  = 0;
    last_w = '0;
    while (cnt < N && it < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (it % 2 == 0);
        default: v = 1'($urandom % 2);
      endcase
      w = rand_word();
      s_valid = v;
      s_data = w;
      start = 1'($urandom % 2);
      pool_result_valid = 1'($urandom % 2);
      pool_result = rand_word();
      tick();
      it++;
      if (v) begin
        cnt++;
        last_w = w;
        chk("stream_pool_data", pool_data, w);
      end
      chk("stream_pool_valid", pool_valid, v);
      chk("stream_pixel_cnt", pixel_cnt, cnt);
      chk("stream_pool_clear", pool_clear, 0);
      chk("stream_m_valid", m_valid, 0);
      chk("stream_s_ready", s_ready, (cnt < N));
    end
    chk("stream_all_words", cnt, N);
    start = 1'b0;
    pool_result_valid = 1'b0;

    if (lat < 0) begin
      for (int k = 1; k <= TO; k++) begin
        s_valid = 1'b1;
        s_data = rand_word();
        tick();
        chk("to_m_valid", m_valid, 0);
        chk("to_pool_valid", pool_valid, 0);
        if (k < TO) begin
          chk("to_busy_early", busy, 1);
          chk("to_err_early", timeout_err, 0);
        end else begin
          chk("to_err_set", timeout_err, 1);
          chk("to_busy_clear", busy, 0);
        end
      end
      s_valid = 1'b0;
      tick();
      chk("to_err_sticky", timeout_err, 1);
      chk("to_m_valid_after", m_valid, 0);
      return;
    end

    for (int k = 0; k < lat; k++) begin
      s_valid = 1'b1;
      s_data = rand_word();
      tick();
      chk("wait_pool_valid", pool_valid, 0);
      chk("wait_pool_data_hold", pool_data, last_w);
      chk("wait_pixel_cnt", pixel_cnt, N);
      chk("wait_busy", busy, 1);
      chk("wait_m_valid", m_valid, 0);
    end
    s_valid = 1'b0;
    pool_result = res;
    pool_result_valid = 1'b1;
    tick();
    pool_result_valid = 1'b0;
    pool_result = rand_word();
    chk("cap_m_valid", m_valid, 1);
    chk("cap_m_data", m_data, res);
    chk("cap_timeout_err", timeout_err, 0);
    chk("cap_s_ready", s_ready, 0);

    for (int k = 0; k < hold; k++) begin
      m_ready = 1'b0;
      pool_result_valid = 1'($urandom % 2);
      pool_result = rand_word();
      tick();
      chk("hold_m_valid", m_valid, 1);
      chk("hold_m_data", m_data, res);
      chk("hold_frame_done", frame_done, 0);
      chk("hold_busy", busy, 1);
    end
    pool_result_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("done_m_valid", m_valid, 0);
    chk("done_frame_done", frame_done, 1);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    s_data = '0;
    s_valid = 1'b0;
    pool_result = '0;
    pool_result_valid = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    do_frame({CH{32'h3F800000}}, 2, 0, 0);
    tick();
    chk("frame_done_single", frame_done, 0);

    do_frame(rand_word(), 3, 5, 1);
    do_frame('0, -1, 0, 2);
    do_frame(rand_word(), TO - 1, 1, 2);
    // back-to-back: start on the edge right after frame_done
    do_frame(rand_word(), 0, 0, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data = rand_word();
      tick();
    end
    chk("mid_pixel_cnt", pixel_cnt, 2);
    rst = 1'b1;
    s_valid = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    do_frame(rand_word(), 1, 2, 0);

    for (int f = 0; f < 4; f++)
      do_frame(rand_word(), int'($urandom_range(0, TO - 1)), int'($urandom_range(0, 4)), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
